// File: rtl/mesh_output_arbiter.sv
// Round-robin arbiter sharing one mesh output link among NUM_IN input stages, with a single output slot.
// Optional MESH_ARB_STALL_CNT_EN adds a saturating count of backpressure cycles on the stall_cnt port.

package Mesh;
    typedef struct packed {
        logic [7:0]  dst;
        logic [23:0] payload;
    } Packet;
endpackage

// state   | meaning
// S_EMPTY | output slot holds no packet, valid=0
// S_FULL  | output slot holds a packet, valid=1
module mesh_output_arbiter #(
    parameter int NUM_IN = 5,
    parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] request,
    input  Mesh::Packet       packet_in [NUM_IN],
    output logic [NUM_IN-1:0] grant,
    output Mesh::Packet       packet_out,
    output logic              valid,
    input  logic              ready
`ifdef MESH_ARB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t           state_q, state_d;
    Mesh::Packet      slot_q, slot_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] scan_idx;
    logic             found;
    logic             free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            slot_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        ptr_d    = ptr_q;
        grant    = '0;
        win_idx  = ptr_q;
        scan_idx = ptr_q;
        found    = 1'b0;
        free     = (state_q == S_EMPTY) || ready;

        // First set request at or after ptr, wrapping modulo NUM_IN.
        for (int k = 0; k < NUM_IN; k++) begin
            scan_idx = IDX_W'((int'(ptr_q) + k) % NUM_IN);
            if (!found && request[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end

        if (free) begin
            if (found) begin
                grant   = NUM_IN'(1) << win_idx;
                state_d = S_FULL;
                slot_d  = packet_in[win_idx];
                ptr_d   = (win_idx == IDX_W'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                state_d = S_EMPTY;
            end
        end

        // Reset is asynchronous, so the combinational grant must be masked too.
        if (!rst_n) begin
            grant = '0;
        end
    end

    assign valid      = (state_q == S_FULL);
    assign packet_out = slot_q;

`ifdef MESH_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (valid && !ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mesh_output_arbiter.sv
// Directed bench for mesh_output_arbiter: vector table for reset, round-robin, backpressure and wrap,
// plus hand sequences for fairness, packet stability under stall and (MESH_ARB_STALL_CNT_EN) stall_cnt.

module tb_mesh_output_arbiter;

    typedef struct {
        logic        rst_n;
        logic [4:0]  req;
        logic        rdy;
        logic [4:0]  exp_grant;
        logic        exp_valid;
        logic        chk_pkt;
        Mesh::Packet exp_pkt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  request;
    Mesh::Packet packet_in [5];
    logic [4:0]  grant;
    Mesh::Packet packet_out;
    logic        valid;
    logic        ready;
`ifdef MESH_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mesh_output_arbiter #(.NUM_IN(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .request    (request),
        .packet_in  (packet_in),
        .grant      (grant),
        .packet_out (packet_out),
        .valid      (valid),
        .ready      (ready)
`ifdef MESH_ARB_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic Mesh::Packet pk(int i);
        return Mesh::Packet'(32'hC0DE_0000 + i * 32'h0101);
    endfunction

    function automatic vec_t mk(logic r, logic [4:0] q, logic y, logic [4:0] g,
                                logic v, logic c, Mesh::Packet p);
        vec_t t;
        t.rst_n = r; t.req = q; t.rdy = y; t.exp_grant = g;
        t.exp_valid = v; t.chk_pkt = c; t.exp_pkt = p;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    vec_t vecs [24];

    initial begin
        int mp;
        int last;

        rst_n   = 1'b0;
        request = 5'h1F;
        ready   = 1'b1;
        for (int i = 0; i < 5; i++) packet_in[i] = pk(i);

        // reset
        vecs[0]  = mk(0, 5'h1F,    1, 5'b00000, 0, 1, '0);
        // single requester, slot empty
        vecs[1]  = mk(1, 5'b00100, 1, 5'b00100, 0, 1, '0);
        vecs[2]  = mk(1, 5'b00000, 0, 5'b00000, 1, 1, pk(2));
        // all requesting, ptr=3 -> 3,4,0,1,2,3,4,0
        vecs[3]  = mk(1, 5'h1F,    1, 5'b01000, 1, 1, pk(2));
        vecs[4]  = mk(1, 5'h1F,    1, 5'b10000, 1, 1, pk(3));
        vecs[5]  = mk(1, 5'h1F,    1, 5'b00001, 1, 1, pk(4));
        vecs[6]  = mk(1, 5'h1F,    1, 5'b00010, 1, 1, pk(0));
        vecs[7]  = mk(1, 5'h1F,    1, 5'b00100, 1, 1, pk(1));
        vecs[8]  = mk(1, 5'h1F,    1, 5'b01000, 1, 1, pk(2));
        vecs[9]  = mk(1, 5'h1F,    1, 5'b10000, 1, 1, pk(3));
        vecs[10] = mk(1, 5'h1F,    1, 5'b00001, 1, 1, pk(4));
        // backpressure with ptr=1
        vecs[11] = mk(1, 5'h03,    0, 5'b00000, 1, 1, pk(0));
        vecs[12] = mk(1, 5'h03,    0, 5'b00000, 1, 1, pk(0));
        vecs[13] = mk(1, 5'h03,    0, 5'b00000, 1, 1, pk(0));
        vecs[14] = mk(1, 5'h03,    0, 5'b00000, 1, 1, pk(0));
        vecs[15] = mk(1, 5'h03,    1, 5'b00010, 1, 1, pk(0));
        // wrap/skip: ptr=2 -> grant3 (ptr=4) -> grant1 -> grant3
        vecs[16] = mk(1, 5'b01000, 1, 5'b01000, 1, 1, pk(1));
        vecs[17] = mk(1, 5'b01010, 1, 5'b00010, 1, 1, pk(3));
        vecs[18] = mk(1, 5'b01010, 1, 5'b01000, 1, 1, pk(1));
        // drain to empty
        vecs[19] = mk(1, 5'b00000, 1, 5'b00000, 1, 1, pk(3));
        vecs[20] = mk(1, 5'b00000, 0, 5'b00000, 0, 0, '0);
        // empty slot is free even with ready=0; then reset mid-transfer
        vecs[21] = mk(1, 5'b10000, 0, 5'b10000, 0, 0, '0);
        vecs[22] = mk(0, 5'h1F,    0, 5'b00000, 0, 1, '0);
        vecs[23] = mk(1, 5'b00001, 0, 5'b00001, 0, 1, '0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst_n   = vecs[i].rst_n;
            request = vecs[i].req;
            ready   = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            chk($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_pkt)
                chk($sformatf("vec%0d packet_out", i), packet_out, vecs[i].exp_pkt);
        end

        // Fairness: ptr=1, slot holds pk(0); all request continuously.
        mp   = 1;
        last = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            request = 5'h1F;
            ready   = 1'b1;
            #1;
            chk($sformatf("rr%0d grant", c), 32'(grant), 32'(5'b00001 << mp));
            chk($sformatf("rr%0d valid", c), 32'(valid), 32'd1);
            chk($sformatf("rr%0d packet_out", c), packet_out, pk(last));
            last = mp;
            mp   = (mp + 1) % 5;
        end

        // Stall while packet_in changes: output must hold pk(last), no grant.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            request = 5'h03;
            ready   = 1'b0;
            for (int i = 0; i < 5; i++) packet_in[i] = Mesh::Packet'(32'hDEAD_0000 + c * 16 + i);
            #1;
            chk($sformatf("stall%0d grant", c), 32'(grant), 32'd0);
            chk($sformatf("stall%0d packet_out", c), packet_out, pk(last));
        end
        for (int i = 0; i < 5; i++) packet_in[i] = pk(i);
        @(negedge clk);
        ready = 1'b1;
        #1;
        chk("release grant", 32'(grant), 32'(5'b00010));
        chk("release packet_out", packet_out, pk(last));
        @(negedge clk);
        request = 5'h00;
        ready   = 1'b0;
        #1;
        chk("after release packet_out", packet_out, pk(1));

`ifdef MESH_ARB_STALL_CNT_EN
        repeat (70000) @(negedge clk);
        #1;
        chk("stall_cnt saturate", 32'(stall_cnt), 32'h0000_FFFF);
        rst_n = 1'b0;
        #1;
        chk("stall_cnt reset", 32'(stall_cnt), 32'd0);
        chk("valid reset", 32'(valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
